sram_array_ctrl: RTL and testbench

//  Initiator-side controller for a 1R1W masked SRAM macro (512x12, 2 mask segments of 6 bits).

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_array_ctrl_if.sv | 30 +++
 rtl/sram_resp_buf.sv | 47 ++++
 rtl/sram_array_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_array_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the masked 1R1W SRAM array controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_DEPTH  = 512;
  localparam int unsigned SRAM_ADDR_W = 9;
  localparam int unsigned SRAM_DATA_W = 12;
  localparam int unsigned SRAM_MASK_W = 2;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

  typedef struct packed {
    logic [SRAM_DATA_W-1:0] data;
    logic                   oor;
  } resp_entry_t;

endpackage

// File: rtl/sram_array_ctrl_if.sv
// Client request/response channel of the SRAM array controller.
interface sram_array_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W,
  parameter int unsigned MASK_W = SRAM_MASK_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram_resp_buf.sv
// Two-entry response FIFO; contents are only meaningful while occ says so.
module sram_resp_buf
  import sram_ctrl_pkg::*;
#(
  parameter type entry_t = resp_entry_t
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] occ
);

  entry_t slots [2];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   do_push;
  logic   do_pop;

  assign do_pop  = pop  && (occ != 2'd0);
  assign do_push = push && (occ != 2'd2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/sram_array_ctrl.sv
// Initiator-side controller for a 1R1W masked SRAM macro with 1-cycle read latency.
// Optional power-on array clear: define SRAM_ARRAY_CTRL_INIT_CLEAR_EN.
module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = SRAM_DEPTH,
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W,
  parameter int unsigned MASK_W = SRAM_MASK_W
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_array_ctrl_if.slave  bus,
  output logic              init_done,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              oor;
  } entry_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              addr_ok;
  logic              rd_room;
  logic              accept;
  logic              rd_acc;
  logic              wr_acc;
  logic              inflight;
  logic              inflight_oor;
  logic [1:0]        buf_occ;
  logic              buf_push;
  logic              buf_pop;
  entry_t            buf_head;
  entry_t            inflight_word;
  logic              init_active;
  logic [ADDR_W-1:0] init_addr;

  assign addr_ok = ({1'b0, bus.req_addr} < DEPTH_L);
  assign rd_room = (({1'b0, inflight} + buf_occ) < 2'd2);

  assign bus.req_ready = init_done & (bus.req_write | rd_room);
  assign accept        = bus.req_valid & bus.req_ready;
  assign rd_acc        = accept & ~bus.req_write;
  assign wr_acc        = accept &  bus.req_write;

  always_comb begin
    R0_en   = rd_acc & addr_ok;
    R0_addr = bus.req_addr;
    W0_en   = wr_acc & addr_ok;
    W0_addr = bus.req_addr;
    W0_data = bus.req_wdata;
    W0_mask = bus.req_wmask;
    if (init_active) begin
      W0_en   = 1'b1;
      W0_addr = init_addr;
      W0_data = '0;
      W0_mask = '1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight     <= 1'b0;
      inflight_oor <= 1'b0;
    end else begin
      inflight     <= rd_acc;
      inflight_oor <= rd_acc & ~addr_ok;
    end
  end

  // The out-of-range flag rides with the word; zeroing happens at the output mux.
  assign inflight_word.data = R0_data;
  assign inflight_word.oor  = inflight_oor;

  assign buf_pop  = (buf_occ != 2'd0) & bus.resp_ready;
  assign buf_push = inflight & ~((buf_occ == 2'd0) & bus.resp_ready);

  sram_resp_buf #(
    .entry_t (entry_t)
  ) u_resp_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (buf_push),
    .push_data (inflight_word),
    .pop       (buf_pop),
    .head      (buf_head),
    .occ       (buf_occ)
  );

  always_comb begin
    bus.resp_valid = inflight | (buf_occ != 2'd0);
    if (buf_occ != 2'd0) begin
      bus.resp_rdata = buf_head.oor ? '0 : buf_head.data;
    end else begin
      bus.resp_rdata = inflight_word.oor ? '0 : inflight_word.data;
    end
  end

`ifdef SRAM_ARRAY_CTRL_INIT_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ctrl_state_e       state;
  ctrl_state_e       state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = RUN;
      end
      RUN:     ;
      default: state_nxt = INIT;
    endcase
  end

  assign init_active = (state == INIT);
  assign init_addr   = cnt;
  assign init_done   = (state == RUN);
`else
  assign init_active = 1'b0;
  assign init_addr   = '0;
  assign init_done   = 1'b1;
`endif

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench for sram_array_ctrl with a behavioural masked 1R1W macro model.
module tb_sram_array_ctrl;

  localparam int unsigned DEPTH  = 500;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned MASK_W = 2;
  localparam int unsigned SEG    = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_done;
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [DATA_W-1:0] R0_data;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [DATA_W-1:0] W0_data;
  logic [MASK_W-1:0] W0_mask;

  int checks = 0;
  int errors = 0;

  sram_array_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  sram_array_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MASK_W (MASK_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .init_done (init_done),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_data   (R0_data),
    .W0_addr   (W0_addr),
    .W0_en     (W0_en),
    .W0_data   (W0_data),
    .W0_mask   (W0_mask)
  );

  always #5 clock = ~clock;

  // Macro model: masked write, registered read, seeded with a nonzero pattern.
  logic [DATA_W-1:0] mem [512];
  logic              seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) mem[i] <= DATA_W'(12'h5A5 ^ i);
      seeded <= 1'b1;
    end
    if (W0_en) begin
      for (int s = 0; s < int'(MASK_W); s++)
        if (W0_mask[s]) mem[W0_addr][s*SEG +: SEG] <= W0_data[s*SEG +: SEG];
    end
    if (R0_en) R0_data <= mem[R0_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic              exp_en;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t              vecs [$];
  logic [DATA_W-1:0] got [$];
  logic [DATA_W-1:0] exp_bp [3];
  int                cyc;
  logic              acc;

  task automatic drive(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [MASK_W-1:0] wmask);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (n < 2000) begin
      @(posedge clock); #1;
      n++;
      if (init_done) break;
    end
    check(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_r0_en", 32'(R0_en), 32'd0);

`ifdef SRAM_ARRAY_CTRL_INIT_CLEAR_EN
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_w0_en_init", 32'(W0_en), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("init_first_addr", 32'(W0_addr), 32'd0);
    check("init_first_mask", 32'(W0_mask), 32'h3);
    check("init_first_data", 32'(W0_data), 32'd0);
    repeat (100) @(posedge clock);
    #1;
    check("init_addr_100", 32'(W0_addr), 32'd100);
    check("init_ready_low", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("init_restart_addr", 32'(W0_addr), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("init_cycles");
    drive(1'b0, 9'd200, '0, '0);
    #3;
    check("init_rd_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    check("init_rd_valid", 32'(bus.resp_valid), 32'd1);
    check("init_rd_zero", 32'(bus.resp_rdata), 32'd0);
`else
    check("rst_init_done", 32'(init_done), 32'd1);
    check("rst_w0_en", 32'(W0_en), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
`endif

    // wr, addr, wdata, wmask, expected macro enable, expected read data
    vecs.push_back('{1'b1, 9'd5,   12'hABC, 2'b11, 1'b1, 12'h000});
    vecs.push_back('{1'b0, 9'd5,   12'h000, 2'b00, 1'b1, 12'hABC});
    vecs.push_back('{1'b1, 9'd7,   12'hFFF, 2'b11, 1'b1, 12'h000});
    vecs.push_back('{1'b1, 9'd7,   12'h000, 2'b01, 1'b1, 12'h000});
    vecs.push_back('{1'b0, 9'd7,   12'h000, 2'b00, 1'b1, 12'hFC0});
    vecs.push_back('{1'b1, 9'd5,   12'h0F0, 2'b10, 1'b1, 12'h000});
    vecs.push_back('{1'b0, 9'd5,   12'h000, 2'b00, 1'b1, 12'h0FC});
    vecs.push_back('{1'b1, 9'd1,   12'h111, 2'b11, 1'b1, 12'h000});
    vecs.push_back('{1'b1, 9'd2,   12'h222, 2'b11, 1'b1, 12'h000});
    vecs.push_back('{1'b1, 9'd3,   12'h333, 2'b11, 1'b1, 12'h000});
    vecs.push_back('{1'b1, 9'd499, 12'h5C3, 2'b11, 1'b1, 12'h000});
    vecs.push_back('{1'b0, 9'd499, 12'h000, 2'b00, 1'b1, 12'h5C3});
    vecs.push_back('{1'b1, 9'd500, 12'h123, 2'b11, 1'b0, 12'h000});
    vecs.push_back('{1'b1, 9'd510, 12'h5A5, 2'b11, 1'b0, 12'h000});
    vecs.push_back('{1'b0, 9'd510, 12'h000, 2'b00, 1'b0, 12'h000});

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      #3;
      check($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'd1);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_w0_en", i), 32'(W0_en), 32'(vecs[i].exp_en));
        check($sformatf("vec%0d_r0_en", i), 32'(R0_en), 32'd0);
      end else begin
        check($sformatf("vec%0d_r0_en", i), 32'(R0_en), 32'(vecs[i].exp_en));
        check($sformatf("vec%0d_w0_en", i), 32'(W0_en), 32'd0);
        if (vecs[i].exp_en) check($sformatf("vec%0d_r0_addr", i), 32'(R0_addr), 32'(vecs[i].addr));
      end
      @(posedge clock); #1;
      if (!vecs[i].wr) begin
        check($sformatf("vec%0d_resp_valid", i), 32'(bus.resp_valid), 32'd1);
        check($sformatf("vec%0d_rdata", i), 32'(bus.resp_rdata), 32'(vecs[i].exp_rdata));
      end
    end
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);

    // Backpressure: two reads outstanding, third blocked, writes still ready.
    bus.resp_ready = 1'b0;
    drive(1'b0, 9'd1, '0, '0);
    #3;
    check("bp_rd1_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    drive(1'b0, 9'd2, '0, '0);
    #3;
    check("bp_rd2_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    drive(1'b0, 9'd3, '0, '0);
    #3;
    check("bp_rd3_blocked", 32'(bus.req_ready), 32'd0);
    check("bp_head_valid", 32'(bus.resp_valid), 32'd1);
    check("bp_head_data", 32'(bus.resp_rdata), 32'h111);
    bus.req_write = 1'b1;
    #1;
    check("bp_write_ready", 32'(bus.req_ready), 32'd1);
    bus.req_write = 1'b0;
    @(posedge clock); #1;
    #3;
    check("bp_rd3_still_blocked", 32'(bus.req_ready), 32'd0);
    @(posedge clock); #1;
    bus.resp_ready = 1'b1;
    exp_bp[0] = 12'h111;
    exp_bp[1] = 12'h222;
    exp_bp[2] = 12'h333;
    got.delete();
    cyc = 0;
    while (cyc < 20 && got.size() < 3) begin
      #2;
      if (bus.resp_valid) got.push_back(bus.resp_rdata);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clock); #1;
      if (acc) bus.req_valid = 1'b0;
      cyc++;
    end
    check("bp_resp_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) check($sformatf("bp_resp%0d", i), 32'(got[i]), 32'(exp_bp[i]));
    bus.req_valid = 1'b0;
    @(posedge clock); #1;

    // Streaming: 16 back-to-back reads, one response per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, ADDR_W'(16 + i), DATA_W'(i * 12'h51 + 7), 2'b11);
      #3;
      check($sformatf("st_wr%0d_en", i), 32'(W0_en), 32'd1);
      @(posedge clock); #1;
    end
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, ADDR_W'(16 + i), '0, '0);
      #3;
      check($sformatf("st_rd%0d_ready", i), 32'(bus.req_ready), 32'd1);
      @(posedge clock); #1;
      if (bus.resp_valid) cyc++;
      check($sformatf("st_rd%0d_data", i), 32'(bus.resp_rdata), 32'(DATA_W'(i * 12'h51 + 7)));
    end
    bus.req_valid = 1'b0;
    check("st_resp_count", 32'(cyc), 32'd16);
    @(posedge clock); #1;
    check("st_drained", 32'(bus.resp_valid), 32'd0);

    // Reset with two reads outstanding discards them.
    bus.resp_ready = 1'b0;
    drive(1'b0, 9'd1, '0, '0);
    @(posedge clock); #1;
    drive(1'b0, 9'd2, '0, '0);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    check("rm_pending_valid", 32'(bus.resp_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rm_r0_en", 32'(R0_en), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    check("rm_after_release", 32'(bus.resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
